uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1-compatible. It is the receive-side partner of the team's uart_tx, using the same baud divider parameterisation.
- Input framing: the line idles high; each frame is a start bit (0), 8 data bits LSB first, then one or more stop bits (1). Two stop bits from uart_tx are accepted.
- The received byte is presented on a valid/ack holding register to the keyboard/host logic, with framing-error and overrun indications.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 30 +++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART types and constants for uart_rx / uart_tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CD_MAX    = 10416;
  localparam int UART_CD_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;
endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module  : uart_sync2
// Purpose : Two-flop synchroniser for an idle-high asynchronous input.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Purpose : 8N1 UART receiver with valid/ack holding register, ferr, overrun.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CD_MAX   = UART_CD_MAX,
  parameter int CD_WIDTH = UART_CD_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rbus,
  output logic       valid,
  input  logic       ack,
  output logic       ferr,
  output logic       overrun
);
  localparam logic [CD_WIDTH-1:0] c_CD_MAX   = CD_WIDTH'(CD_MAX);
  localparam logic [CD_WIDTH-1:0] c_H        = CD_WIDTH'(CD_MAX / 2);
  localparam logic [CD_WIDTH-1:0] c_CD_ONE   = CD_WIDTH'(1);
  localparam logic [2:0]          c_LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  uart_state_e               r_state, w_state_nxt;
  logic [CD_WIDTH-1:0]       r_cd, w_cd_nxt;
  logic [2:0]                r_idx, w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                      w_deliver;
  logic                      w_ferr;
  logic [7:0]                r_rbus;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_overrun;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cd_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_cd == c_H) begin
          w_cd_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end
        end else begin
          w_cd_nxt = r_cd + c_CD_ONE;
        end
      end
      DATA: begin
        if (r_cd == c_CD_MAX) begin
          w_cd_nxt    = '0;
          w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
          if (r_idx == c_LAST_BIT) w_state_nxt = STOP;
          else                     w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cd_nxt = r_cd + c_CD_ONE;
        end
      end
      STOP: begin
        if (r_cd == c_CD_MAX) begin
          w_cd_nxt = '0;
          if (w_rx_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_cd_nxt = r_cd + c_CD_ONE;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot look like a fresh start bit.
        w_cd_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cd    <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Holding register: a completed byte is dropped if the previous one is still unconsumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rbus    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ferr    <= w_ferr;
      r_overrun <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || ack) begin
          r_rbus  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rbus    = r_rbus;
  assign valid   = r_valid;
  assign ferr    = r_ferr;
  assign overrun = r_overrun;
endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Purpose : Self-checking scoreboard bench for uart_rx (CD_MAX=15).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
  localparam int CDM = 15;
  localparam int H   = CDM / 2;
  localparam int BIT = CDM + 1;
  localparam int LAT = 2 + 1 + H + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rbus;
  logic       valid;
  logic       ferr;
  logic       overrun;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         deliv_cnt = 0;
  int         deliv_cyc = -1;
  bit         mon_en = 1'b0;
  bit         auto_ack = 1'b0;
  bit         man_ack = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CD_MAX(CDM), .CD_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rbus    (rbus),
    .valid   (valid),
    .ack     (ack),
    .ferr    (ferr),
    .overrun (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nstop, input logic stopv);
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BIT);
    end
    rx = stopv;
    tick(BIT * nstop);
  endtask

  // Monitor: a new byte is on rbus when valid is high and the register was empty or just consumed.
  initial begin : monitor
    logic       pv;
    logic [7:0] prbus;
    logic [7:0] e;
    pv    = 1'b0;
    prbus = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mon_en) begin
        pv = 1'b0;
      end else begin
        if (ferr)    ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (ferr || overrun) check("ferr_ovr_exclusive", {31'd0, ferr & overrun}, 32'd0);
        if (valid && (!pv || ack)) begin
          deliv_cnt++;
          deliv_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%0h expected=none", rbus);
          end else begin
            e = exp_q.pop_front();
            check("rbus_byte", {24'd0, rbus}, {24'd0, e});
          end
        end else if (valid && pv) begin
          check("rbus_hold", {24'd0, rbus}, {24'd0, prbus});
        end
        pv    = valid;
        prbus = rbus;
      end
    end
  end

  // Consumer: either follows the manual ack or acks a waiting byte after a random delay.
  initial begin : consumer
    forever begin
      @(posedge clk);
      #3;
      if (auto_ack) ack = valid && ($urandom_range(0, 2) != 0);
      else          ack = man_ack;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s;
    int d0;
    logic [7:0] rb;
    int ns;

    rst_n = 1'b0;
    tick(3);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_rbus", {24'd0, rbus}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(5);

    // 1: single frame, latency, manual ack
    exp_q.push_back(8'hA5);
    s = cyc + 1;
    send_frame(8'hA5, 1, 1'b1);
    check("t1_latency", deliv_cyc, s + LAT);
    check("t1_valid", {31'd0, valid}, 32'd1);
    check("t1_rbus", {24'd0, rbus}, 32'hA5);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    check("t1_valid_cleared", {31'd0, valid}, 32'd0);
    tick(3);

    // 2: back-to-back frames with two stop bits
    auto_ack = 1'b1;
    d0 = deliv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 2, 1'b1);
    send_frame(8'hFF, 2, 1'b1);
    tick(20);
    auto_ack = 1'b0;
    tick(2);
    check("t2_deliveries", deliv_cnt - d0, 2);
    check("t2_no_errors", ferr_cnt + ovr_cnt, 0);

    // 3: short glitch is a false start
    d0 = deliv_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("t3_no_delivery", deliv_cnt - d0, 0);
    check("t3_valid", {31'd0, valid}, 32'd0);
    check("t3_ferr", ferr_cnt, 0);

    // 4: framing error, held-low line, then recovery
    d0 = deliv_cnt;
    send_frame(8'h3C, 1, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(20);
    check("t4_ferr_once", ferr_cnt, 1);
    check("t4_no_delivery", deliv_cnt - d0, 0);
    check("t4_valid", {31'd0, valid}, 32'd0);
    exp_q.push_back(8'h11);
    auto_ack = 1'b1;
    send_frame(8'h11, 1, 1'b1);
    tick(10);
    auto_ack = 1'b0;
    tick(2);
    check("t4_recovered", deliv_cnt - d0, 1);

    // 5a: overrun while the holding register is full
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1, 1'b1);
    tick(5);
    send_frame(8'h66, 1, 1'b1);
    tick(5);
    check("t5_overrun_once", ovr_cnt, 1);
    check("t5_rbus_kept", {24'd0, rbus}, 32'h55);
    check("t5_valid_kept", {31'd0, valid}, 32'd1);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    check("t5_valid_cleared", {31'd0, valid}, 32'd0);

    // 5b: ack coinciding with the delivery edge replaces the byte without overrun
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1, 1'b1);
    tick(5);
    exp_q.push_back(8'h66);
    s = cyc + 1;
    fork
      send_frame(8'h66, 1, 1'b1);
      begin
        tick(LAT);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
      end
    join
    check("t5b_latency", deliv_cyc, s + LAT);
    check("t5b_rbus", {24'd0, rbus}, 32'h66);
    check("t5b_valid", {31'd0, valid}, 32'd1);
    check("t5b_no_overrun", ovr_cnt, 1);

    // 6: reset during data bit 3, held until the frame is over
    fork
      send_frame(8'h81, 1, 1'b1);
      begin
        tick(70);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        check("t6_rst_rbus", {24'd0, rbus}, 32'd0);
        check("t6_rst_ferr", {31'd0, ferr}, 32'd0);
        check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
      end
    join
    tick(2);
    rst_n = 1'b1;
    tick(10);
    d0 = deliv_cnt;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1, 1'b1);
    tick(2);
    check("t6_after_reset", deliv_cnt - d0, 1);
    check("t6_rbus", {24'd0, rbus}, 32'h42);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;

    // Random frames with random gaps, stop lengths and ack delays
    auto_ack = 1'b1;
    d0 = deliv_cnt;
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      ns = int'($urandom_range(1, 2));
      exp_q.push_back(rb);
      send_frame(rb, ns, 1'b1);
      tick(int'($urandom_range(0, 6)));
    end
    tick(20);
    auto_ack = 1'b0;
    tick(2);
    check("rand_deliveries", deliv_cnt - d0, 20);
    check("rand_ferr", ferr_cnt, 1);
    check("rand_overrun", ovr_cnt, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
